// File: rtl/shiftreg_out_driver.sv
// Serialises accepted parallel words onto a 74HC595-style data/clock/latch interface.
// Optional macro AUTO_LOAD_EN: self-start a frame whenever data_in differs from the last accepted value.
module shiftreg_out_driver #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              sr_data,
    output logic              sr_clk,
    output logic              sr_latch,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ready_q, ready_d;
    logic              sr_data_q, sr_data_d;
    logic              sr_clk_q, sr_clk_d;
    logic              sr_latch_q, sr_latch_d;
    logic              done_q, done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              start_c;
    logic [DATA_W-1:0] shreg_adv_c;

    // Bit that goes on the wire first for a given shift-register content.
    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    assign shreg_adv_c = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

`ifdef AUTO_LOAD_EN
    logic [DATA_W-1:0] last_q;

    assign start_c = (state_q == ST_IDLE) && ((valid && ready_q) || (data_in != last_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (start_c) begin
            last_q <= data_in;
        end
    end
`else
    assign start_c = valid && ready_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            ready_q     <= 1'b1;
            sr_data_q   <= 1'b0;
            sr_clk_q    <= 1'b0;
            sr_latch_q  <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            ready_q     <= ready_d;
            sr_data_q   <= sr_data_d;
            sr_clk_q    <= sr_clk_d;
            sr_latch_q  <= sr_latch_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // sr_clk_q doubles as the half-period flag: 0 = low phase, 1 = high phase.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        ready_d     = ready_q;
        sr_data_d   = sr_data_q;
        sr_clk_d    = sr_clk_q;
        sr_latch_d  = sr_latch_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d   = ST_SHIFT;
                    phase_d   = '0;
                    bit_d     = '0;
                    shreg_d   = data_in;
                    ready_d   = 1'b0;
                    sr_clk_d  = 1'b0;
                    sr_data_d = head_bit(data_in);
                end
            end
            ST_SHIFT: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + PH_W'(1);
                end else begin
                    phase_d = '0;
                    if (!sr_clk_q) begin
                        sr_clk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d    = ST_LATCH;
                        sr_clk_d   = 1'b0;
                        sr_data_d  = 1'b0;
                        sr_latch_d = 1'b1;
                    end else begin
                        bit_d     = bit_q + BIT_W'(1);
                        shreg_d   = shreg_adv_c;
                        sr_clk_d  = 1'b0;
                        sr_data_d = head_bit(shreg_adv_c);
                    end
                end
            end
            ST_LATCH: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + PH_W'(1);
                end else begin
                    phase_d     = '0;
                    state_d     = ST_IDLE;
                    sr_latch_d  = 1'b0;
                    ready_d     = 1'b1;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ready_d    = 1'b1;
                sr_clk_d   = 1'b0;
                sr_data_d  = 1'b0;
                sr_latch_d = 1'b0;
            end
        endcase
    end

    assign ready     = ready_q;
    assign sr_data   = sr_data_q;
    assign sr_clk    = sr_clk_q;
    assign sr_latch  = sr_latch_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_shiftreg_out_driver.sv
// Scoreboard bench: instance 0 is CLK_DIV=1 MSB-first, instance 1 is CLK_DIV=4 LSB-first.
// A protocol monitor decodes each serial frame and compares it with the expected queue on done.
module tb_shiftreg_out_driver;

    localparam int unsigned DIV0 = 1;
    localparam int unsigned DIV1 = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] din;
    logic [1:0]      valid;
    logic [1:0]      ready, sr_data, sr_clk, sr_latch, done;
    logic [1:0][7:0] fcnt;

    int nchk = 0;
    int nerr = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [7:0]  fc[2];

    int          busy[2], lo[2], hi[2], lat[2], bad[2], bits[2];
    logic [7:0]  rx[2];
    logic        prev[2];
    logic [15:0] ev;
    int          qs;

    shiftreg_out_driver #(.DATA_W(8), .CLK_DIV(DIV0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .valid(valid[0]), .ready(ready[0]),
        .sr_data(sr_data[0]), .sr_clk(sr_clk[0]), .sr_latch(sr_latch[0]), .done(done[0]),
        .frame_cnt(fcnt[0])
    );

    shiftreg_out_driver #(.DATA_W(8), .CLK_DIV(DIV1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .valid(valid[1]), .ready(ready[1]),
        .sr_data(sr_data[1]), .sr_clk(sr_clk[1]), .sr_latch(sr_latch[1]), .done(done[1]),
        .frame_cnt(fcnt[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? int'(DIV0) : int'(DIV1);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int i, input logic [7:0] d);
        fc[i] = fc[i] + 8'd1;
        if (i == 0) q0.push_back({fc[i], d});
        else        q1.push_back({fc[i], d});
    endtask

    task automatic clear_mon(input int i);
        busy[i] = 0; lo[i] = 0; hi[i] = 0; lat[i] = 0; bad[i] = 0; bits[i] = 0;
        rx[i] = 8'd0;
    endtask

    // Protocol monitor: measures phase widths, busy/latch lengths and rebuilds the shifted word.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                clear_mon(i);
                prev[i] = 1'b0;
            end else begin
                if (!ready[i]) busy[i]++;
                if (sr_clk[i] && !prev[i]) begin
                    if (lo[i] != div_of(i)) bad[i]++;
                    lo[i] = 0;
                    bits[i]++;
                    if (i == 0) rx[i] = {rx[i][6:0], sr_data[i]};
                    else        rx[i] = {sr_data[i], rx[i][7:1]};
                end
                if (!sr_clk[i] && prev[i]) begin
                    if (hi[i] != div_of(i)) bad[i]++;
                    hi[i] = 0;
                end
                if (sr_clk[i]) hi[i]++;
                else if (!ready[i] && !sr_latch[i]) lo[i]++;
                if (sr_latch[i]) begin
                    lat[i]++;
                    if (sr_data[i] || sr_clk[i]) bad[i]++;
                end
                prev[i] = sr_clk[i];
                if (done[i]) begin
                    qs = qsize(i);
                    chk($sformatf("inst%0d_done_has_expected", i), int'(qs > 0), 1);
                    if (qs > 0) begin
                        ev = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("inst%0d_rx_data", i), int'(rx[i]), int'(ev[7:0]));
                        chk($sformatf("inst%0d_frame_cnt", i), int'(fcnt[i]), int'(ev[15:8]));
                        chk($sformatf("inst%0d_bit_count", i), bits[i], 8);
                        chk($sformatf("inst%0d_ready_low_cycles", i), busy[i], 17 * div_of(i));
                        chk($sformatf("inst%0d_latch_cycles", i), lat[i], div_of(i));
                        chk($sformatf("inst%0d_phase_errors", i), bad[i], 0);
                        chk($sformatf("inst%0d_ready_with_done", i), int'(ready[i]), 1);
                    end
                    clear_mon(i);
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        din[i]   = d;
        valid[i] = 1'b1;
        while (!ready[i] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d_accept_wait", i), int'(ready[i]), 1);
        @(posedge clk);
        push_exp(i, d);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((qsize(i) != 0 || !ready[i]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d_drain", i), qsize(i), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        valid = 2'b00;
        din   = '0;
        fc[0] = 8'd0;
        fc[1] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing moves with valid low.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outs0", int'({ready[0], sr_clk[0], sr_latch[0], sr_data[0], done[0]}), 5'b10000);
            chk("idle_fcnt0", int'(fcnt[0]), 0);
        end
        chk("idle_outs1", int'({ready[1], sr_clk[1], sr_latch[1], sr_data[1], done[1]}), 5'b10000);

`ifdef AUTO_LOAD_EN
        @(negedge clk);
        din[0] = 8'h01;
        push_exp(0, 8'h01);
        wait_idle(0);
        repeat (20) @(negedge clk);
        din[0] = 8'h02;
        push_exp(0, 8'h02);
        wait_idle(0);
        repeat (20) @(negedge clk);
        chk("auto_frame_cnt", int'(fcnt[0]), 2);
`else
        send(0, 8'hA5);
        wait_idle(0);

        send(1, 8'h01);
        wait_idle(1);

        // Busy-time valid is dropped; a held valid is taken on the first ready cycle.
        send(0, 8'h3C);
        repeat (4) @(negedge clk);
        din[0]   = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        din[0]   = 8'h0F;
        n = 0;
        while (!done[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", int'(done[0]), 1);
        push_exp(0, 8'h0F);
        @(negedge clk);
        valid[0] = 1'b0;
        chk("b2b_accept_first_ready_cycle", int'(ready[0]), 0);
        wait_idle(0);
        chk("b2b_frame_cnt", int'(fcnt[0]), 3);

        // Asynchronous reset in the middle of bit 4.
        send(0, 8'hC3);
        repeat (8) @(negedge clk);
        chk("midframe_busy", int'(ready[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs0", int'({ready[0], sr_clk[0], sr_latch[0], sr_data[0], done[0]}), 5'b10000);
        chk("rst_async_fcnt0", int'(fcnt[0]), 0);
        chk("rst_async_fcnt1", int'(fcnt[1]), 0);
        q0.delete();
        fc[0] = 8'd0;
        fc[1] = 8'd0;
        @(negedge clk);
        chk("rst_no_latch", int'(sr_latch[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h81);
        wait_idle(0);

        // 256 completed frames since reset bring frame_cnt back to 0.
        for (int k = 0; k < 255; k++) send(0, 8'(k));
        wait_idle(0);
        chk("wrap_frame_cnt", int'(fcnt[0]), 0);
`endif

        wait_idle(0);
        wait_idle(1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
